// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified IF/MEM memory arbiter: FSM encoding,
// default widths and the saturating increment used by the statistics counters.
package mem_arb_pkg;

  localparam int unsigned AW_DEF          = 32;
  localparam int unsigned DW_DEF          = 32;
  localparam int unsigned TIMEOUT_CYC_DEF = 64;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DATA  = 2'd1;
  localparam logic [1:0] ST_FETCH = 2'd2;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    if (v == 32'hFFFF_FFFF) begin
      return v;
    end else begin
      return v + 32'd1;
    end
  endfunction

endpackage

// File: rtl/arb_timeout_cnt.sv
// Watchdog for an outstanding RAM access: cleared on grant, counts cycles
// without ack, and flags expiry on the last allowed wait cycle.
module arb_timeout_cnt #(
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] LAST_C = CW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] ONE_C  = CW'(1);

  logic [CW-1:0] cnt_r;

  // Wait-cycle counter; holds at the last value until the abort clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (en && (cnt_r != LAST_C)) begin
      cnt_r <= cnt_r + ONE_C;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expire = en & (cnt_r == LAST_C);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates a single-ported unified memory between fetch and load/store,
// data first. Optional statistics counters are enabled by ARB_STATS_EN.
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW          = AW_DEF,
  parameter int unsigned DW          = DW_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ready,
  input  logic          mem_rd,
  input  logic          mem_wr,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_wdata,
  output logic [DW-1:0] mem_rdata,
  output logic          mem_ready,
  output logic          ram_req,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  input  logic          ram_ack,
  output logic          stall_if,
  output logic          stall_mem,
  output logic          ram_err
`ifdef ARB_STATS_EN
  ,
  output logic [31:0]   conflict_cnt,
  output logic [31:0]   ram_busy_cnt
`endif
);

  logic [1:0] state_r;
  logic       idle_s;
  logic       grant_s;
  logic       expire_s;

  // A requester whose ready pulse is showing is finished, so it is masked from
  // the grant; this lets the ready cycle grant the other side without a bubble.
  assign stall_if  = if_req & ~if_ready;
  assign stall_mem = (mem_rd | mem_wr) & ~mem_ready;
  assign idle_s    = (state_r == ST_IDLE);
  assign grant_s   = idle_s & (stall_mem | stall_if);

  arb_timeout_cnt #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clr    (grant_s),
    .en     (ram_req & ~ram_ack),
    .expire (expire_s)
  );

  // Arbitration FSM and registered RAM/requester interface.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      ram_req   <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      if_ready  <= 1'b0;
      mem_ready <= 1'b0;
      ram_err   <= 1'b0;
      if_rdata  <= '0;
      mem_rdata <= '0;
    end else begin
      if_ready  <= 1'b0;
      mem_ready <= 1'b0;
      ram_err   <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (stall_mem) begin
            // rd&wr together is not legal; it resolves to a store.
            state_r   <= ST_DATA;
            ram_req   <= 1'b1;
            ram_we    <= mem_wr;
            ram_addr  <= mem_addr;
            ram_wdata <= mem_wdata;
          end else if (stall_if) begin
            state_r  <= ST_FETCH;
            ram_req  <= 1'b1;
            ram_we   <= 1'b0;
            ram_addr <= if_addr;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_DATA, ST_FETCH: begin
          if (ram_ack) begin
            state_r <= ST_IDLE;
            ram_req <= 1'b0;
            ram_we  <= 1'b0;
            if (state_r == ST_DATA) begin
              mem_ready <= 1'b1;
              if (!ram_we) begin
                mem_rdata <= ram_rdata;
              end else begin
                mem_rdata <= mem_rdata;
              end
            end else begin
              if_ready <= 1'b1;
              if_rdata <= ram_rdata;
            end
          end else if (expire_s) begin
            // Abort; the requester is still stalled and retries from IDLE.
            state_r <= ST_IDLE;
            ram_req <= 1'b0;
            ram_we  <= 1'b0;
            ram_err <= 1'b1;
          end else begin
            state_r <= state_r;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          ram_req <= 1'b0;
          ram_we  <= 1'b0;
        end
      endcase
    end
  end

`ifdef ARB_STATS_EN
  // Saturating conflict and RAM-occupancy counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_cnt <= 32'd0;
      ram_busy_cnt <= 32'd0;
    end else begin
      if (idle_s && stall_mem && stall_if) begin
        conflict_cnt <= sat_inc32(conflict_cnt);
      end else begin
        conflict_cnt <= conflict_cnt;
      end
      if (ram_req) begin
        ram_busy_cnt <= sat_inc32(ram_busy_cnt);
      end else begin
        ram_busy_cnt <= ram_busy_cnt;
      end
    end
  end
`endif

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed self-checking bench for unified_mem_arbiter (TIMEOUT_CYC=4).
module tb_unified_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        ram_req;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        ram_ack;
  logic        stall_if;
  logic        stall_mem;
  logic        ram_err;
`ifdef ARB_STATS_EN
  logic [31:0] conflict_cnt;
  logic [31:0] ram_busy_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  unified_mem_arbiter #(
    .AW          (32),
    .DW          (32),
    .TIMEOUT_CYC (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ready  (if_ready),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .ram_req   (ram_req),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .ram_ack   (ram_ack),
    .stall_if  (stall_if),
    .stall_mem (stall_mem),
    .ram_err   (ram_err)
`ifdef ARB_STATS_EN
    ,
    .conflict_cnt (conflict_cnt),
    .ram_busy_cnt (ram_busy_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; if_req = 1'b0; if_addr = 32'h0; mem_rd = 1'b0; mem_wr = 1'b0;
    mem_addr = 32'h0; mem_wdata = 32'h0; ram_rdata = 32'h0; ram_ack = 1'b0;

    // Reset state
    tick();
    @(negedge clk);
    chk("rst_ram_req", ram_req, 32'd0);
    chk("rst_ram_we", ram_we, 32'd0);
    chk("rst_ram_addr", ram_addr, 32'h0);
    chk("rst_ram_wdata", ram_wdata, 32'h0);
    chk("rst_if_ready", if_ready, 32'd0);
    chk("rst_mem_ready", mem_ready, 32'd0);
    chk("rst_ram_err", ram_err, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    chk("rst_mem_rdata", mem_rdata, 32'h0);
    chk("rst_stall_if", stall_if, 32'd0);
    chk("rst_stall_mem", stall_mem, 32'd0);

    // Test 1: fetch only, zero-wait RAM
    tick(); rst = 1'b0; if_req = 1'b1; if_addr = 32'h0040_0000;
    @(negedge clk);
    chk("t1_stall_if", stall_if, 32'd1);
    chk("t1_req_grant_cyc", ram_req, 32'd0);
    tick(); ram_ack = 1'b1; ram_rdata = 32'h1234_5678;
    @(negedge clk);
    chk("t1_ram_req", ram_req, 32'd1);
    chk("t1_ram_addr", ram_addr, 32'h0040_0000);
    chk("t1_ram_we", ram_we, 32'd0);
    chk("t1_no_early_ready", if_ready, 32'd0);
    tick(); ram_ack = 1'b0;
    @(negedge clk);
    chk("t1_if_ready", if_ready, 32'd1);
    chk("t1_if_rdata", if_rdata, 32'h1234_5678);
    chk("t1_stall_if_low", stall_if, 32'd0);
    chk("t1_req_dropped", ram_req, 32'd0);
    tick(); if_req = 1'b0;
    @(negedge clk);
    chk("t1_ready_pulse", if_ready, 32'd0);
    chk("t1_no_regrant", ram_req, 32'd0);

    // Test 2/6: simultaneous load and fetch, back-to-back with zero-wait RAM
    tick(); mem_rd = 1'b1; mem_addr = 32'h1000_0004; if_req = 1'b1; if_addr = 32'h0040_0004;
    @(negedge clk);
    chk("t2_stall_mem", stall_mem, 32'd1);
    chk("t2_stall_if", stall_if, 32'd1);
    tick(); ram_ack = 1'b1; ram_rdata = 32'hCAFE_0001;
    @(negedge clk);
    chk("t2_data_first_addr", ram_addr, 32'h1000_0004);
    chk("t2_data_we", ram_we, 32'd0);
    chk("t2_data_req", ram_req, 32'd1);
    tick(); ram_ack = 1'b0;
    @(negedge clk);
    chk("t2_mem_ready", mem_ready, 32'd1);
    chk("t2_mem_rdata", mem_rdata, 32'hCAFE_0001);
    chk("t2_stall_mem_low", stall_mem, 32'd0);
    chk("t2_if_waiting", stall_if, 32'd1);
    chk("t2_if_not_ready", if_ready, 32'd0);
`ifdef ARB_STATS_EN
    chk("t2_conflict_cnt", conflict_cnt, 32'd1);
    chk("t2_ram_busy_cnt", ram_busy_cnt, 32'd2);
`endif
    tick(); mem_rd = 1'b0; ram_ack = 1'b1; ram_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    chk("t6_fetch_no_bubble", ram_req, 32'd1);
    chk("t6_fetch_addr", ram_addr, 32'h0040_0004);
    chk("t6_mem_ready_pulse", mem_ready, 32'd0);
    tick(); ram_ack = 1'b0;
    @(negedge clk);
    chk("t6_if_ready", if_ready, 32'd1);
    chk("t6_if_rdata", if_rdata, 32'h0BAD_F00D);
    chk("t6_mem_rdata_hold", mem_rdata, 32'hCAFE_0001);
    tick(); if_req = 1'b0;
    @(negedge clk);
    chk("t6_idle", ram_req, 32'd0);

    // Test 3: store with 3 wait states (ack on last allowed cycle)
    tick(); mem_wr = 1'b1; mem_addr = 32'h1000_0008; mem_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("t3_grant_cyc", ram_req, 32'd0);
    tick(); mem_wdata = 32'h0000_0000;
    @(negedge clk);
    chk("t3_ram_req", ram_req, 32'd1);
    chk("t3_ram_we", ram_we, 32'd1);
    chk("t3_ram_addr", ram_addr, 32'h1000_0008);
    chk("t3_wdata_w1", ram_wdata, 32'hDEAD_BEEF);
    for (int i = 0; i < 2; i++) begin
      tick();
      @(negedge clk);
      chk("t3_wdata_wait", ram_wdata, 32'hDEAD_BEEF);
      chk("t3_no_ready_wait", mem_ready, 32'd0);
    end
    tick(); ram_ack = 1'b1; ram_rdata = 32'h5555_AAAA;
    @(negedge clk);
    chk("t3_wdata_ack", ram_wdata, 32'hDEAD_BEEF);
    chk("t3_we_ack", ram_we, 32'd1);
    tick(); ram_ack = 1'b0;
    @(negedge clk);
    chk("t3_mem_ready", mem_ready, 32'd1);
    chk("t3_mem_rdata_unch", mem_rdata, 32'hCAFE_0001);
    chk("t3_no_err", ram_err, 32'd0);
    chk("t3_req_low", ram_req, 32'd0);
    tick(); mem_wr = 1'b0;
    @(negedge clk);
    chk("t3_ready_pulse", mem_ready, 32'd0);

    // Test 4: timeout with TIMEOUT_CYC=4, then retry
    tick(); if_req = 1'b1; if_addr = 32'h0040_0010;
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clk);
      chk("t4_req_held", ram_req, 32'd1);
      chk("t4_no_err_yet", ram_err, 32'd0);
    end
    tick();
    @(negedge clk);
    chk("t4_ram_err", ram_err, 32'd1);
    chk("t4_req_aborted", ram_req, 32'd0);
    chk("t4_no_ready", if_ready, 32'd0);
    chk("t4_still_stalled", stall_if, 32'd1);
    tick(); ram_ack = 1'b1; ram_rdata = 32'h7777_0000;
    @(negedge clk);
    chk("t4_regrant", ram_req, 32'd1);
    chk("t4_err_pulse", ram_err, 32'd0);
    chk("t4_retry_addr", ram_addr, 32'h0040_0010);
    tick(); ram_ack = 1'b0;
    @(negedge clk);
    chk("t4_if_ready", if_ready, 32'd1);
    chk("t4_if_rdata", if_rdata, 32'h7777_0000);
    tick(); if_req = 1'b0;

    // Test 5: reset mid-fetch, stale ack afterwards
    tick(); if_req = 1'b1; if_addr = 32'h0040_0020;
    tick(); rst = 1'b1;
    @(negedge clk);
    chk("t5_in_fetch", ram_req, 32'd1);
    chk("t5_fetch_addr", ram_addr, 32'h0040_0020);
    tick(); rst = 1'b0; if_req = 1'b0; ram_ack = 1'b1; ram_rdata = 32'h9999_9999;
    @(negedge clk);
    chk("t5_req_reset", ram_req, 32'd0);
    chk("t5_addr_reset", ram_addr, 32'h0);
    chk("t5_if_rdata_reset", if_rdata, 32'h0);
    chk("t5_mem_rdata_reset", mem_rdata, 32'h0);
    chk("t5_no_ready", if_ready, 32'd0);
    tick(); ram_ack = 1'b0;
    @(negedge clk);
    chk("t5_stale_ack_ignored", if_ready, 32'd0);
    chk("t5_rdata_stays", if_rdata, 32'h0);
    chk("t5_idle", ram_req, 32'd0);

    // rd&wr together resolves to a store
    tick(); mem_rd = 1'b1; mem_wr = 1'b1; mem_addr = 32'h1000_000C; mem_wdata = 32'h1111_2222;
    tick(); ram_ack = 1'b1; ram_rdata = 32'hABCD_ABCD;
    @(negedge clk);
    chk("rw_is_store", ram_we, 32'd1);
    chk("rw_wdata", ram_wdata, 32'h1111_2222);
    tick(); ram_ack = 1'b0;
    @(negedge clk);
    chk("rw_mem_ready", mem_ready, 32'd1);
    chk("rw_rdata_unch", mem_rdata, 32'h0);
    tick(); mem_rd = 1'b0; mem_wr = 1'b0;
    @(negedge clk);
    chk("rw_ready_pulse", mem_ready, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
